// File: rtl/sized_memory.sv
// Byte-addressable 32-bit little-endian memory with byte/halfword/word access and optional sign extension.
// Latency: aligned and error responses arrive 1 cycle after accept; misaligned (split) accesses arrive 2 cycles after accept.
// Backpressure: o_ready drops for the single SPLIT cycle of a misaligned access and during reset; otherwise one access per cycle.
//
// Ports: i_clk/i_rst_n (sync active-low); request i_req/o_ready with i_addr, i_data, i_size, i_we (0=write, 1=read), i_signed;
//        response o_valid pulse with o_data (read data, 0 for writes/errors) and o_err.
// Build option: define SIZED_MEMORY_ALIGN_CHECK_EN to turn misaligned accesses into error responses instead of splitting them.
module sized_memory #(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_data,
    input  logic [1:0]        i_size,
    input  logic              i_we,
    input  logic              i_signed,
    output logic [31:0]       o_data,
    output logic              o_valid,
    output logic              o_err
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int WA_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

`ifdef SIZED_MEMORY_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t state, state_nxt;

    // One byte array per lane; lane L of word W holds byte address 4*W+L.
    logic [7:0] mem [4][WORDS];

    logic        ready_q, valid_q, err_q;
    logic [31:0] data_q;

    // Context of a split access carried from beat 1 into beat 2.
    logic [WA_W-1:0] sp_word;
    logic [1:0]      sp_off;
    logic [2:0]      sp_n;
    logic            sp_write, sp_signed;
    logic [31:0]     sp_wdata, sp_rdata;

    logic            accept, rsvd, aligned, misal, reject;
    logic [2:0]      req_n;
    logic [WA_W-1:0] req_word;

    // Single memory port shared by a fresh request (beat 1) and the SPLIT beat 2.
    logic            port_en, port_beat2, port_write, port_signed;
    logic [WA_W-1:0] port_word;
    logic [1:0]      port_off;
    logic [2:0]      port_n;
    logic [31:0]     port_wdata;
    logic [1:0]      lane_idx [4];
    logic [3:0]      lane_en;
    logic [7:0]      lane_wbyte [4];
    logic [31:0]     rd_bytes;

    logic unused_addr;
    assign unused_addr = ^i_addr;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n, input logic sgn);
        case (n)
            3'd1:    return {{24{sgn & raw[7]}}, raw[7:0]};
            3'd2:    return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_comb begin
        accept   = i_req && ready_q && i_rst_n;
        rsvd     = (i_size == 2'b10);
        req_word = i_addr[WA_W+1:2];
        case (i_size)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            2'b11:   req_n = 3'd4;
            default: req_n = 3'd0;
        endcase
        aligned = (i_size == 2'b00)
               || (i_size == 2'b01 && !i_addr[0])
               || (i_size == 2'b11 && i_addr[1:0] == 2'b00);
        misal   = !rsvd && !aligned;
        reject  = rsvd || (misal && ALIGN_CHECK);
    end

    always_comb begin
        if (state == SPLIT) begin
            // Beat 2 is dropped when reset lands in the SPLIT cycle.
            port_en     = i_rst_n;
            port_beat2  = 1'b1;
            port_word   = sp_word;
            port_off    = sp_off;
            port_n      = sp_n;
            port_write  = sp_write;
            port_signed = sp_signed;
            port_wdata  = sp_wdata;
        end else begin
            port_en     = accept && !reject;
            port_beat2  = 1'b0;
            port_word   = req_word;
            port_off    = i_addr[1:0];
            port_n      = req_n;
            port_write  = !i_we;
            port_signed = i_signed;
            port_wdata  = i_data;
        end
    end

    // Byte index within the access is (lane - offset) mod 4 for both beats:
    // beat 1 owns lanes at/above the offset, beat 2 the lanes below it.
    always_comb begin
        rd_bytes = port_beat2 ? sp_rdata : 32'h0;
        for (int l = 0; l < 4; l++) begin
            lane_idx[l]   = 2'(l) - port_off;
            lane_en[l]    = (port_beat2 ? (2'(l) < port_off) : (2'(l) >= port_off))
                         && ({1'b0, lane_idx[l]} < port_n);
            lane_wbyte[l] = port_wdata[{lane_idx[l], 3'b000} +: 8];
            if (lane_en[l]) begin
                rd_bytes[{lane_idx[l], 3'b000} +: 8] = mem[l][port_word];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !reject && misal) state_nxt = SPLIT;
            SPLIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (accept && reject) begin
                valid_q <= 1'b1;
                err_q   <= 1'b1;
                data_q  <= 32'h0;
            end else if (port_en && (port_beat2 || !misal)) begin
                valid_q <= 1'b1;
                data_q  <= port_write ? 32'h0 : extend(rd_bytes, port_n, port_signed);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && port_en) begin
            sp_word   <= req_word + WA_W'(1);
            sp_off    <= i_addr[1:0];
            sp_n      <= req_n;
            sp_write  <= !i_we;
            sp_signed <= i_signed;
            sp_wdata  <= i_data;
            sp_rdata  <= rd_bytes;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 4; l++) begin
            if (port_en && port_write && lane_en[l]) begin
                mem[l][port_word] <= lane_wbyte[l];
            end
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_data  = data_q;

endmodule

// File: doc/sized_memory.md
SIZED_MEMORY -- requirements
Module: sized_memory

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of i_addr.
REQ-002 Parameter MEM_BYTES, default 65536, storage size in bytes; power of two, multiple of 4, at most 2**ADDR_W.
REQ-003 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous and active-low.
REQ-005 i_req  in  1  access request valid.
REQ-006 o_ready  out  1  block can accept a request this cycle.
REQ-007 i_addr  in  ADDR_W  byte address.
REQ-008 i_data  in  32  write data, right-justified for byte/halfword.
REQ-009 i_size  in  2  00 byte, 01 halfword, 11 word, 10 reserved.
REQ-010 i_we  in  1  0 = write, 1 = read.
REQ-011 i_signed  in  1  sign-extend byte/halfword read data.
REQ-012 o_data  out  32  read data, right-justified.
REQ-013 o_valid  out  1  one-cycle response pulse, for reads, writes and errors.
REQ-014 o_err  out  1  response is an error; qualified by o_valid.

Function
REQ-015 Storage is little-endian: byte at address A occupies lane A[1:0] of word A/4.
REQ-016 Address bits at and above log2(MEM_BYTES) are ignored; byte addresses wrap modulo MEM_BYTES.
REQ-017 A request is accepted on a rising edge with i_req=1 and o_ready=1; i_addr, i_data, i_size, i_we and i_signed are sampled only at acceptance.
REQ-018 FSM states: IDLE (o_ready=1) and SPLIT (o_ready=0).
REQ-019 An aligned access is one whose address is a multiple of its size: byte always, halfword A[0]=0, word A[1:0]=00.
REQ-020 An aligned access is performed at the accepting edge; o_valid=1 in the following cycle and the FSM stays in IDLE; back-to-back requests sustain one access per cycle.
REQ-021 A misaligned access moves IDLE->SPLIT. Beat 1 at the accepting edge covers lanes A[1:0]..3. Beat 2 on the next edge covers the remaining bytes at the following word address, wrapping per REQ-016. The FSM then returns to IDLE. o_valid is asserted two cycles after acceptance.
REQ-022 Misaligned read data is assembled from both beats in address order; misaligned write bytes are written in address order across both beats.
REQ-023 Writes update only the addressed bytes; all other bytes are unchanged.
REQ-024 Read: o_data is zero-extended when i_signed=0. When i_signed=1, byte reads extend bit 7 and halfword reads extend bit 15. Word reads ignore i_signed.
REQ-025 On a write or error response o_data=0. Between responses o_data holds its last value.
REQ-026 i_size=10: no memory change; o_valid=1 and o_err=1 in the next cycle.
REQ-027 o_err=0 on every successful response.

Reset
REQ-028 While i_rst_n=0 at a rising edge: o_ready=0, o_valid=0, o_err=0, o_data=0, FSM=IDLE.
REQ-029 o_ready=1 in the first cycle after i_rst_n returns high.
REQ-030 Reset in SPLIT abandons the access: beat-1 write bytes stay committed, beat 2 is not performed, and no response is issued.
REQ-031 Memory contents are not cleared by reset.

Configuration
REQ-032 Macro SIZED_MEMORY_ALIGN_CHECK_EN.
REQ-033 Macro defined: a misaligned access causes no memory change and no SPLIT; o_valid=1, o_err=1, o_data=0 one cycle after acceptance.
REQ-034 Macro undefined: misaligned accesses are split per REQ-021; the SPLIT state is still compiled.

Verification
REQ-035 Write word 0x11223344 @0x0000, then read byte @0x0001 with i_signed=0 -> o_data=0x00000033, o_valid one cycle after accept, o_err=0.
REQ-036 Write 0xA5B6C7D8 @0x0004, read halfword @0x0006 with i_signed=1 -> 0xFFFFA5B6; same read with i_signed=0 -> 0x0000A5B6.
REQ-037 With the REQ-035/036 contents, macro undefined: read word @0x0002 -> o_ready=0 for one cycle, o_valid two cycles after accept, o_data=0xC7D81122. Macro defined: o_err=1 and o_data=0 after one cycle.
REQ-038 MEM_BYTES=65536, macro undefined: write word 0xDEADBEEF @0xFFFE. Then byte reads return 0xEF @0xFFFE, 0xBE @0xFFFF, 0xAD @0x0000 and 0xDE @0x0001.
REQ-039 Read with i_size=10 -> o_valid=1, o_err=1, memory unchanged. Then pulse i_rst_n low during SPLIT of a misaligned write -> no response, o_ready=1 the cycle after reset ends.
